// File: rtl/piece_scheduler.sv
// Piece/column scheduler: shares one random word per cycle between the piece
// preview FIFO refill and the garbage-row hole-column client.
module piece_scheduler #(
    parameter int NUM_PIECES = 7,
    parameter int DEPTH      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] rnd,
    input  logic       piece_req,
    output logic       piece_ack,
    output logic [2:0] piece_out,
    output logic [2:0] preview,
    output logic       preview_valid,
    input  logic       col_req,
    output logic       col_ack,
    output logic [2:0] col_out
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]    fifo_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    last_q, last_d;
    logic          norep_q, norep_d;
    logic          rr_q, rr_d;
    logic          piece_ack_q, piece_ack_d;
    logic [2:0]    piece_out_q, piece_out_d;
    logic          col_ack_q, col_ack_d;
    logic [2:0]    col_out_q, col_out_d;

    logic       pop, push, refill_want, col_want, grant_refill, grant_col;
    logic [2:0] cand;
    logic       cand_legal, cand_repeat;

    always_comb begin
        pop         = piece_req && (count_q != '0) && !piece_ack_q;
        refill_want = (count_q < CW'(DEPTH)) || pop;
        col_want    = col_req && !col_ack_q;
        // rr_q set means COL is favoured on the next contested cycle
        grant_refill = refill_want && (!col_want || !rr_q);
        grant_col    = col_want && (!refill_want || rr_q);
        rr_d         = (refill_want && col_want) ? ~rr_q : rr_q;

        cand        = rnd[2:0];
        cand_legal  = (32'(cand) < NUM_PIECES);
        cand_repeat = (cand == last_q);
        push        = grant_refill && cand_legal && !(cand_repeat && !norep_q);

        last_d  = last_q;
        norep_d = norep_q;
        if (grant_refill && cand_legal) begin
            if (cand_repeat && !norep_q) begin
                norep_d = 1'b1;
            end else begin
                norep_d = 1'b0;
                last_d  = cand;
            end
        end

        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        if (push) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        piece_ack_d = pop;
        piece_out_d = pop ? fifo_q[rd_q] : piece_out_q;
        col_ack_d   = grant_col;
        col_out_d   = grant_col ? rnd[9:7] : col_out_q;
    end

    // Write into the tail slot; when full with a pop, that slot is the head
    // being read out this same cycle, so ordering is preserved.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    fifo_q[gi] <= 3'd0;
                end else if (push && (wr_q == PW'(gi))) begin
                    fifo_q[gi] <= cand;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            last_q      <= 3'd7;
            norep_q     <= 1'b0;
            rr_q        <= 1'b0;
            piece_ack_q <= 1'b0;
            piece_out_q <= 3'd0;
            col_ack_q   <= 1'b0;
            col_out_q   <= 3'd0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            norep_q     <= norep_d;
            rr_q        <= rr_d;
            piece_ack_q <= piece_ack_d;
            piece_out_q <= piece_out_d;
            col_ack_q   <= col_ack_d;
            col_out_q   <= col_out_d;
        end
    end

    assign piece_ack     = piece_ack_q;
    assign piece_out     = piece_out_q;
    assign col_ack       = col_ack_q;
    assign col_out       = col_out_q;
    assign preview_valid = (count_q != '0);
    assign preview       = (count_q != '0) ? fifo_q[rd_q] : 3'd0;

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed bench for piece_scheduler: fill, delivery, contention, empty wait,
// full push+pop and mid-handshake reset scenarios.
module tb_piece_scheduler;
    logic       clk;
    logic       reset;
    logic [9:0] rnd;
    logic       piece_req;
    logic       piece_ack;
    logic [2:0] piece_out;
    logic [2:0] preview;
    logic       preview_valid;
    logic       col_req;
    logic       col_ack;
    logic [2:0] col_out;

    int passed = 0;
    int total  = 0;

    piece_scheduler #(.NUM_PIECES(7), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rnd          (rnd),
        .piece_req    (piece_req),
        .piece_ack    (piece_ack),
        .piece_out    (piece_out),
        .preview      (preview),
        .preview_valid(preview_valid),
        .col_req      (col_req),
        .col_ack      (col_ack),
        .col_out      (col_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_rnd(input logic [2:0] col, input logic [2:0] c);
        rnd = {col, 4'b0000, c};
    endtask

    initial begin
        reset = 1'b1; piece_req = 1'b0; col_req = 1'b0; set_rnd(3'd0, 3'd7);
        step(); step();
        chk("rst_piece_ack", 32'(piece_ack), 0);
        chk("rst_col_ack", 32'(col_ack), 0);
        chk("rst_piece_out", 32'(piece_out), 0);
        chk("rst_col_out", 32'(col_out), 0);
        chk("rst_preview", 32'(preview), 0);
        chk("rst_preview_valid", 32'(preview_valid), 0);
        reset = 1'b0;

        // Fill: 7,7 rejected; 3 pushed; 3 rejected (flag set); 3 pushed; 5 finds FIFO full
        set_rnd(3'd0, 3'd7); step();
        set_rnd(3'd0, 3'd7); step();
        chk("fill_reject7_valid", 32'(preview_valid), 0);
        set_rnd(3'd0, 3'd3); step();
        chk("fill_first_valid", 32'(preview_valid), 1);
        chk("fill_first_preview", 32'(preview), 3);
        set_rnd(3'd0, 3'd3); step();
        set_rnd(3'd0, 3'd3); step();
        set_rnd(3'd0, 3'd5); step();
        chk("fill_full_preview", 32'(preview), 3);
        set_rnd(3'd0, 3'd7); piece_req = 1'b1; step();
        chk("fill_pop1_ack", 32'(piece_ack), 1);
        chk("fill_pop1_out", 32'(piece_out), 3);
        step();
        chk("fill_ackcycle_nopop", 32'(piece_ack), 0);
        chk("fill_second_preview", 32'(preview), 3);
        step();
        chk("fill_pop2_ack", 32'(piece_ack), 1);
        chk("fill_pop2_out", 32'(piece_out), 3);
        piece_req = 1'b0; step();
        chk("fill_drained_valid", 32'(preview_valid), 0);

        // Delivery from {3,5}
        reset = 1'b1; step(); reset = 1'b0;
        set_rnd(3'd0, 3'd3); step();
        set_rnd(3'd0, 3'd5); step();
        chk("deliv_preview_head", 32'(preview), 3);
        set_rnd(3'd0, 3'd7); piece_req = 1'b1; step();
        piece_req = 1'b0;
        chk("deliv_ack", 32'(piece_ack), 1);
        chk("deliv_out", 32'(piece_out), 3);
        chk("deliv_preview_next", 32'(preview), 5);
        step();
        chk("deliv_ack_single", 32'(piece_ack), 0);
        chk("deliv_out_hold", 32'(piece_out), 3);

        // Contention with count 1: REFILL wins first (rejects 7), then COL
        set_rnd(3'd6, 3'd7); col_req = 1'b1; step();
        chk("cont_first_refill", 32'(col_ack), 0);
        step();
        col_req = 1'b0;
        chk("cont_second_col_ack", 32'(col_ack), 1);
        chk("cont_col_out", 32'(col_out), 6);
        step();
        chk("cont_col_ack_once", 32'(col_ack), 0);
        chk("cont_col_out_hold", 32'(col_out), 6);
        chk("cont_preview_kept", 32'(preview), 5);

        // Empty wait
        reset = 1'b1; step(); reset = 1'b0;
        chk("ewait_rst_col_out", 32'(col_out), 0);
        chk("ewait_rst_piece_out", 32'(piece_out), 0);
        piece_req = 1'b1; set_rnd(3'd0, 3'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ewait_no_ack", 32'(piece_ack), 0);
        end
        set_rnd(3'd0, 3'd4); step();
        chk("ewait_push_ack", 32'(piece_ack), 0);
        chk("ewait_push_valid", 32'(preview_valid), 1);
        set_rnd(3'd0, 3'd7); step();
        piece_req = 1'b0;
        chk("ewait_ack", 32'(piece_ack), 1);
        chk("ewait_out", 32'(piece_out), 4);

        // Full push+pop
        reset = 1'b1; step(); reset = 1'b0;
        set_rnd(3'd0, 3'd1); step();
        set_rnd(3'd0, 3'd2); step();
        piece_req = 1'b1; set_rnd(3'd0, 3'd5); step();
        set_rnd(3'd0, 3'd7);
        chk("full_pp_ack", 32'(piece_ack), 1);
        chk("full_pp_out", 32'(piece_out), 1);
        chk("full_pp_preview", 32'(preview), 2);
        step();
        chk("full_pp_ackcycle", 32'(piece_ack), 0);
        step();
        chk("full_pp_out2", 32'(piece_out), 2);
        step();
        step();
        chk("full_pp_ack3", 32'(piece_ack), 1);
        chk("full_pp_out3", 32'(piece_out), 5);
        piece_req = 1'b0; step();
        chk("full_pp_empty", 32'(preview_valid), 0);

        // Reset arriving with an accepted pop
        set_rnd(3'd0, 3'd3); step();
        chk("rst_hs_pushed", 32'(preview_valid), 1);
        piece_req = 1'b1; set_rnd(3'd0, 3'd7); reset = 1'b1; step();
        chk("rst_hs_no_ack", 32'(piece_ack), 0);
        chk("rst_hs_valid", 32'(preview_valid), 0);
        chk("rst_hs_preview", 32'(preview), 0);
        chk("rst_hs_piece_out", 32'(piece_out), 0);
        chk("rst_hs_col_out", 32'(col_out), 0);
        reset = 1'b0; piece_req = 1'b0; step();
        chk("rst_hs_still_no_ack", 32'(piece_ack), 0);
        set_rnd(3'd0, 3'd3); step();
        chk("rst_hs_last_cleared", 32'(preview_valid), 1);
        chk("rst_hs_last_preview", 32'(preview), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
